// File: rtl/hpf_coef_mult_if.sv
// hpf_coef_mult_if: sample/coefficient request side and scaled-product result side
// of the HPF coefficient multiplier.
interface hpf_coef_mult_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 16,
  parameter int TAG_W = 5
);
  logic                    in_valid;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic signed [OUT_W-1:0] p;
  logic [TAG_W-1:0]        out_tag;
  logic                    sat;

  modport master (
    output in_valid, a, b, in_tag,
    input  out_valid, p, out_tag, sat
  );

  modport slave (
    input  in_valid, a, b, in_tag,
    output out_valid, p, out_tag, sat
  );
endinterface

// File: rtl/hpf_coef_mult.sv
// hpf_coef_mult: pipelined signed multiply, arithmetic right shift, saturation and
// overflow counting. Define HPF_MULT_ROUND_EN for round-half-up before the shift.
module hpf_coef_mult #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int PIPE  = 3,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] ovf_count,
  hpf_coef_mult_if.slave   bus
);
  localparam int P_W = A_W + B_W;
  localparam int X_W = P_W + 1;
  localparam int unsigned DLY = PIPE - 3;

  localparam logic signed [X_W-1:0] Q_MAX = {{(X_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] Q_MIN = {{(X_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef HPF_MULT_ROUND_EN
  localparam logic signed [X_W-1:0] RND =
    (SHIFT > 0) ? ({{(X_W-1){1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
  localparam logic signed [X_W-1:0] RND = '0;
`endif

  logic signed [A_W-1:0]   a_q;
  logic signed [B_W-1:0]   b_q;
  logic [TAG_W-1:0]        tag1_q;
  logic                    v1_q;

  // Index 0 is the product register; higher indices are the pure delay stages.
  logic signed [P_W-1:0]   prod_q [DLY+1];
  logic [TAG_W-1:0]        tag_q  [DLY+1];
  logic                    v_q    [DLY+1];

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] p_q;
  logic [TAG_W-1:0]        out_tag_q;
  logic                    sat_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  logic signed [X_W-1:0]   ext_d;
  logic signed [X_W-1:0]   q_d;
  logic signed [OUT_W-1:0] p_d;
  logic                    sat_d;

  always_comb begin
    ext_d = {prod_q[DLY][P_W-1], prod_q[DLY]} + RND;
    q_d   = ext_d >>> SHIFT;
    p_d   = q_d[OUT_W-1:0];
    sat_d = 1'b0;
    if (q_d > Q_MAX) begin
      p_d   = Q_MAX[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (q_d < Q_MIN) begin
      p_d   = Q_MIN[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  // Clear beats a coincident saturation event; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_ovf) begin
      cnt_d = '0;
    end else if (v_q[DLY] && sat_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      tag1_q      <= '0;
      v1_q        <= 1'b0;
      for (int unsigned i = 0; i < DLY + 1; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
        v_q[i]    <= 1'b0;
      end
      out_valid_q <= 1'b0;
      p_q         <= '0;
      out_tag_q   <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (ce) begin
      a_q       <= bus.a;
      b_q       <= bus.b;
      tag1_q    <= bus.in_tag;
      v1_q      <= bus.in_valid;
      prod_q[0] <= $signed({{B_W{a_q[A_W-1]}}, a_q}) * $signed({{A_W{b_q[B_W-1]}}, b_q});
      tag_q[0]  <= tag1_q;
      v_q[0]    <= v1_q;
      for (int unsigned i = DLY; i > 0; i--) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        v_q[i]    <= v_q[i-1];
      end
      out_valid_q <= v_q[DLY];
      sat_q       <= v_q[DLY] & sat_d;
      if (v_q[DLY]) begin
        p_q       <= p_d;
        out_tag_q <= tag_q[DLY];
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.sat       = sat_q;
  assign ovf_count     = cnt_q;
endmodule

// File: tb/tb_hpf_coef_mult.sv
// tb_hpf_coef_mult: directed vectors against an arithmetic reference model of the
// multiplier, plus literal expectations; a CNT_W=2 copy exercises counter saturation.
`timescale 1ns/1ps
module tb_hpf_coef_mult;
  localparam int A_W   = 16;
  localparam int B_W   = 16;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int PIPE  = 3;
  localparam int TAG_W = 5;
`ifdef HPF_MULT_ROUND_EN
  localparam longint R_POS = 2;
  localparam longint R_NEG = -1;
`else
  localparam longint R_POS = 1;
  localparam longint R_NEG = -2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        clr_ovf;
  logic [15:0] ovf_count;
  logic [1:0]  ovf_count2;

  int checks = 0;
  int errors = 0;

  hpf_coef_mult_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus1 ();
  hpf_coef_mult_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus2 ();

  assign bus2.in_valid = bus1.in_valid;
  assign bus2.a        = bus1.a;
  assign bus2.b        = bus1.b;
  assign bus2.in_tag   = bus1.in_tag;

  hpf_coef_mult #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .PIPE(PIPE),
                  .TAG_W(TAG_W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ce(ce), .clr_ovf(clr_ovf),
    .ovf_count(ovf_count), .bus(bus1)
  );

  hpf_coef_mult #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .PIPE(PIPE),
                  .TAG_W(TAG_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .clr_ovf(clr_ovf),
    .ovf_count(ovf_count2), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, optional half-LSB add, floor shift, clip to OUT_W.
  function automatic void ref_calc(input longint av, input longint bv,
                                   output longint pv, output bit sv);
    longint x;
    longint maxv;
    longint minv;
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -(longint'(1) << (OUT_W - 1));
    x = av * bv;
`ifdef HPF_MULT_ROUND_EN
    if (SHIFT > 0) x = x + (longint'(1) << (SHIFT - 1));
`endif
    x = x >>> SHIFT;
    sv = 1'b1;
    if (x > maxv)      pv = maxv;
    else if (x < minv) pv = minv;
    else begin
      pv = x;
      sv = 1'b0;
    end
  endfunction

  typedef struct {
    bit               v;
    longint           p;
    bit               s;
    logic [TAG_W-1:0] t;
  } slot_t;

  slot_t            mp [PIPE];
  bit               m_v;
  bit               m_s;
  longint           m_p;
  logic [TAG_W-1:0] m_t;
  longint           m_cnt;
  longint           m_cnt2;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) mp[i] = '{v: 1'b0, p: 0, s: 1'b0, t: '0};
      m_v = 1'b0; m_s = 1'b0; m_p = 0; m_t = '0; m_cnt = 0; m_cnt2 = 0;
    end else if (ce) begin
      slot_t n;
      n.v = bus1.in_valid;
      n.t = bus1.in_tag;
      ref_calc(longint'(bus1.a), longint'(bus1.b), n.p, n.s);
      for (int i = PIPE - 1; i > 0; i--) mp[i] = mp[i-1];
      mp[0] = n;
      m_v = mp[PIPE-1].v;
      m_s = mp[PIPE-1].v && mp[PIPE-1].s;
      if (m_v) begin
        m_p = mp[PIPE-1].p;
        m_t = mp[PIPE-1].t;
      end
      if (clr_ovf) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end else if (m_s) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", longint'(bus1.out_valid), longint'(m_v));
      chk("m_p", longint'(bus1.p), m_p);
      chk("m_out_tag", longint'(bus1.out_tag), longint'(m_t));
      chk("m_sat", longint'(bus1.sat), longint'(m_s));
      chk("m_ovf_count", longint'(ovf_count), m_cnt);
      chk("m_ovf_count2", longint'(ovf_count2), m_cnt2);
    end
  end

  bit mon_en = 1'b0;
  int mon_high = 0;
  int tag_seq[$];

  always @(negedge clk) begin
    if (mon_en && bus1.out_valid) begin
      mon_high++;
      if (tag_seq.size() == 0 || tag_seq[$] != int'(bus1.out_tag)) tag_seq.push_back(int'(bus1.out_tag));
    end
  end

  task automatic drive(input bit v, input longint av, input longint bv, input int tag,
                       input bit c = 1'b1, input bit clr = 1'b0, input bit rst = 1'b0);
    @(posedge clk);
    #2;
    bus1.in_valid = v;
    bus1.a        = av[A_W-1:0];
    bus1.b        = bv[B_W-1:0];
    bus1.in_tag   = tag[TAG_W-1:0];
    ce            = c;
    clr_ovf       = clr;
    reset         = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus1.out_valid) begin
        lat = k;
        break;
      end
    end
    chk({name, "_arrived"}, longint'(lat != 0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b1; ce = 1'b1; clr_ovf = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.in_tag = '0;
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", longint'(bus1.out_valid), 0);
    chk("rst_p", longint'(bus1.p), 0);
    chk("rst_out_tag", longint'(bus1.out_tag), 0);
    chk("rst_sat", longint'(bus1.sat), 0);
    chk("rst_ovf_count", longint'(ovf_count), 0);

    drive(1'b1, 16384, -16384, 7);
    idle(1);
    wait_valid("t1", lat);
    chk("t1_latency", lat, PIPE);
    chk("t1_p", longint'(bus1.p), -8192);
    chk("t1_tag", longint'(bus1.out_tag), 7);
    chk("t1_sat", longint'(bus1.sat), 0);

    drive(1'b1, -32768, -32768, 1);
    idle(1);
    wait_valid("t2a", lat);
    chk("t2a_p", longint'(bus1.p), 32767);
    chk("t2a_sat", longint'(bus1.sat), 1);
    chk("t2a_ovf", longint'(ovf_count), 1);
    drive(1'b1, 32767, -32768, 2);
    idle(1);
    wait_valid("t2b", lat);
    chk("t2b_p", longint'(bus1.p), -32767);
    chk("t2b_sat", longint'(bus1.sat), 0);
    chk("t2b_ovf", longint'(ovf_count), 1);

    drive(1'b1, 3, 16384, 3);
    idle(1);
    wait_valid("t3a", lat);
    chk("t3a_round_pos", longint'(bus1.p), R_POS);
    drive(1'b1, -3, 16384, 4);
    idle(1);
    wait_valid("t3b", lat);
    chk("t3b_round_neg", longint'(bus1.p), R_NEG);

    idle(3);
    mon_en = 1'b1;
    drive(1'b1, -1500, -777, 0);
    drive(1'b1, -500, 12345, 1);
    drive(1'b1, 500, -32768, 2);
    drive(1'b1, 1500, 30000, 3, 1'b0);
    drive(1'b1, 1500, 30000, 3, 1'b0);
    drive(1'b1, 1500, 30000, 3);
    drive(1'b1, 2500, -4242, 4);
    idle(8);
    mon_en = 1'b0;
    chk("t4_valid_cycles", mon_high, 7);
    chk("t4_tag_count", tag_seq.size(), 5);
    for (int i = 0; i < tag_seq.size(); i++) chk("t4_tag_order", tag_seq[i], i);

    drive(1'b0, 0, 0, 0, 1'b1, 1'b1);
    drive(1'b1, -32768, -32768, 10);
    drive(1'b1, 32767, 32767, 11);
    drive(1'b1, -32768, 32767, 12);
    drive(1'b0, 0, 0, 0);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1);
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("t5_clr_wins", longint'(ovf_count), 0);
    chk("t5_clr_wins2", longint'(ovf_count2), 0);
    for (int i = 0; i < 5; i++) drive(1'b1, -32768, -32768, 20 + i);
    idle(4);
    chk("t5_count5", longint'(ovf_count), 5);
    chk("t5_count_sat", longint'(ovf_count2), 3);

    drive(1'b1, -32768, -32768, 5);
    drive(1'b1, 1234, 5678, 6);
    drive(1'b1, -2222, 3333, 7);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("t6_out_valid", longint'(bus1.out_valid), 0);
    chk("t6_p", longint'(bus1.p), 0);
    chk("t6_out_tag", longint'(bus1.out_tag), 0);
    chk("t6_sat", longint'(bus1.sat), 0);
    chk("t6_ovf", longint'(ovf_count), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_valid", longint'(bus1.out_valid), 0);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
